// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle datapath control FSM with memory wait timeout
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic       mem_ack,
  output logic       mem_req,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic [1:0] pc_source,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic [3:0] state,
  output logic       err
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_ADDI_EX  = 4'd10,
    S_ADDI_WB  = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     cur;
  state_t     nxt;
  logic [7:0] wait_cnt;
  logic       is_load;
  logic       mem_state;
  logic       timeout;
  logic       illegal_op;

  assign state     = cur;
  assign mem_state = (cur == S_FETCH) || (cur == S_MEM_RD) || (cur == S_MEM_WR);
  // mem_ack on the last allowed cycle wins over the timeout
  assign timeout   = mem_state && !mem_ack && (wait_cnt == WAIT_LAST);

  always_comb begin
    illegal_op = 1'b0;
    case (op)
      OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J, OP_ADDI: illegal_op = 1'b0;
      default:                                       illegal_op = 1'b1;
    endcase
  end

  assign err = rst_n && (timeout || ((cur == S_DECODE) && illegal_op));

  always_comb begin
    nxt = S_FETCH;
    case (cur)
      S_FETCH: begin
        if (mem_ack)      nxt = S_DECODE;
        else              nxt = S_FETCH;
      end
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: nxt = S_MEM_ADDR;
          OP_RTYPE:     nxt = S_R_EXEC;
          OP_BEQ:       nxt = S_BRANCH;
          OP_J:         nxt = S_JUMP;
          OP_ADDI:      nxt = S_ADDI_EX;
          default:      nxt = S_FETCH;
        endcase
      end
      S_MEM_ADDR: nxt = is_load ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: begin
        if (mem_ack)      nxt = S_MEM_WB;
        else if (timeout) nxt = S_FETCH;
        else              nxt = S_MEM_RD;
      end
      S_MEM_WB: nxt = S_FETCH;
      S_MEM_WR: begin
        if (mem_ack)      nxt = S_FETCH;
        else if (timeout) nxt = S_FETCH;
        else              nxt = S_MEM_WR;
      end
      S_R_EXEC:  nxt = S_R_WB;
      S_R_WB:    nxt = S_FETCH;
      S_BRANCH:  nxt = S_FETCH;
      S_JUMP:    nxt = S_FETCH;
      S_ADDI_EX: nxt = S_ADDI_WB;
      S_ADDI_WB: nxt = S_FETCH;
      default:   nxt = S_FETCH;
    endcase
  end

  // op is only valid in DECODE, so the load/store choice is latched there
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur      <= S_FETCH;
      wait_cnt <= 8'd0;
      is_load  <= 1'b0;
    end else begin
      cur <= nxt;
      if (cur == S_DECODE)
        is_load <= (op == OP_LW);
      if ((nxt != cur) || timeout)
        wait_cnt <= 8'd0;
      else if (mem_state && !mem_ack)
        wait_cnt <= wait_cnt + 8'd1;
    end
  end

  always_comb begin
    mem_req       = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 2'b00;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    case (cur)
      S_FETCH: begin
        mem_req   = 1'b1;
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ack && rst_n;
        pc_write  = mem_ack && rst_n;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEM_RD: begin
        mem_req  = 1'b1;
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
      end
      S_ADDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_ADDI_WB: begin
        reg_write = 1'b1;
      end
      default: begin
        mem_req = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
- REQ-001 SHALL have parameter MEM_TIMEOUT, default 16: maximum cycles a memory state waits for mem_ack; legal range 2..255.
- REQ-002 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
- REQ-003 SHALL have port rst_n, input, 1: asynchronous active-low reset.
- REQ-004 SHALL have port op, input, 6: opcode from the instruction register; sampled only in DECODE.
- REQ-005 SHALL have port mem_ack, input, 1: shared instruction/data memory completion, valid while mem_req=1.
- REQ-006 SHALL have port mem_req, output, 1: memory access request.
- REQ-007 SHALL have port iord, output, 1: memory address source; 0 = PC, 1 = ALU result register.
- REQ-008 SHALL have ports mem_read and mem_write, output, 1 each: access type, valid with mem_req.
- REQ-009 SHALL have port ir_write, output, 1: load the instruction register.
- REQ-010 SHALL have ports pc_write and pc_write_cond, output, 1 each: unconditional and branch-conditional PC load.
- REQ-011 SHALL have port pc_source, output, 2: 00 = ALU, 01 = ALU register, 10 = jump target.
- REQ-012 SHALL have port alu_src_a, output, 1: 0 = PC, 1 = register A.
- REQ-013 SHALL have port alu_src_b, output, 2: 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate shifted left by 2.
- REQ-014 SHALL have port alu_op, output, 2: 00 = add, 01 = sub, 10 = funct-decoded (feeds alu_control).
- REQ-015 SHALL have ports reg_dst, reg_write and mem_to_reg, output, 1 each: register-file write controls.
- REQ-016 SHALL have port state, output, 4: current state encoding, for debug.
- REQ-017 SHALL have port err, output, 1: one-cycle pulse on memory timeout or illegal opcode.

Function
- REQ-018 SHALL use these state encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, R_EXEC=6, R_WB=7, BRANCH=8, JUMP=9, ADDI_EX=10, ADDI_WB=11. Codes 12-15 SHALL go to FETCH on the next edge.
- REQ-019 SHALL have all outputs registered-free Moore decodes of state, except pc_write/ir_write in FETCH, which are gated by mem_ack.
- REQ-020 In FETCH it SHALL drive mem_req=1, mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - It SHALL assert ir_write and pc_write only in the cycle mem_ack=1, then go to DECODE.
  - Otherwise it SHALL stay in FETCH.
- REQ-021 In DECODE it SHALL drive alu_src_a=0, alu_src_b=11, alu_op=00 (branch target precompute). Next state by op:
  - 100011 or 101011 -> MEM_ADDR
  - 000000 -> R_EXEC
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - 001000 -> ADDI_EX
  - any other op -> FETCH with err pulsed that cycle.
- REQ-022 MEM_ADDR SHALL drive alu_src_a=1, alu_src_b=10, alu_op=00, then go to MEM_RD if op=100011, else MEM_WR.
- REQ-023 MEM_RD SHALL drive mem_req=1, mem_read=1, iord=1, and wait for mem_ack, then go to MEM_WB.
- REQ-024 MEM_WB SHALL drive reg_write=1, mem_to_reg=1, reg_dst=0, then go to FETCH.
- REQ-025 MEM_WR SHALL drive mem_req=1, mem_write=1, iord=1, and wait for mem_ack, then go to FETCH.
- REQ-026 R_EXEC SHALL drive alu_src_a=1, alu_src_b=00, alu_op=10, then go to R_WB.
- REQ-027 R_WB SHALL drive reg_write=1, reg_dst=1, mem_to_reg=0, then go to FETCH.
- REQ-028 BRANCH SHALL drive alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, then go to FETCH.
- REQ-029 JUMP SHALL drive pc_write=1, pc_source=10, then go to FETCH.
- REQ-030 ADDI_EX SHALL drive alu_src_a=1, alu_src_b=10, alu_op=00, then go to ADDI_WB.
- REQ-031 ADDI_WB SHALL drive reg_write=1, reg_dst=0, mem_to_reg=0, then go to FETCH.
- REQ-032 Control outputs not listed for a state SHALL be 0.
- REQ-033 A wait counter SHALL clear on entry to FETCH, MEM_RD or MEM_WR and increment each cycle mem_ack=0 in those states.
  - When the count reaches MEM_TIMEOUT-1 with mem_ack still 0, the next state SHALL be FETCH, err SHALL pulse, and no ir_write, pc_write or reg_write SHALL occur.
  - mem_ack=1 on that same cycle SHALL take priority: normal completion, no err.
- REQ-034 Instruction latencies from FETCH entry with zero-wait memory SHALL be:
  - lw: 5 cycles
  - sw: 4 cycles
  - R-type and addi: 4 cycles
  - beq and j: 3 cycles
- REQ-035 mem_ack while mem_req=0 SHALL be ignored.

Reset
- REQ-036 rst_n=0 SHALL immediately (asynchronously) force state=FETCH, wait counter=0 and err=0, and drive every other output to its FETCH-state value with mem_ack treated as 0.
- REQ-037 Reset deasserted SHALL start a fetch on the first rising edge; reset asserted mid-instruction SHALL abandon it with no further writes.

Verification
- REQ-038 rst_n low, then released, with mem_ack=1 and op=000000 -> states 0,1,6,7,0; reg_write=1 only in state 7 with reg_dst=1.
- REQ-039 op=100011 with mem_ack delayed 3 cycles in MEM_RD -> states 0,1,2,3,3,3,3,4,0; mem_to_reg=1 in state 4.
- REQ-040 op=000100 -> state 8 shows pc_write_cond=1, alu_op=01, pc_source=01; op=000010 -> state 9 shows pc_write=1, pc_source=10.
- REQ-041 MEM_TIMEOUT=4 and mem_ack held 0 in FETCH -> err pulses on cycle 4, state stays 0, and pc_write/ir_write never assert.
- REQ-042 op=111111 in DECODE -> err pulses one cycle and the next state is 0.
- REQ-043 rst_n asserted during MEM_WR -> state=0 immediately, with mem_write=0 and mem_read=1 combinationally.
